// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and operation modes.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder cell; the combinational core of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first through one full-adder cell and a registered carry.
// state | meaning
// IDLE  | waiting for start; result registers hold the last completed result
// RUN   | one operand bit per clock through the cell
// DONE  | one-cycle done pulse; start here launches the next operation directly
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s, fa_co;
  logic               c_msb;

  fa_cell u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // On the final bit the registered carry is the carry into the MSB.
  assign c_msb = carry_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = (sub == MODE_SUB) ? ~b : b;
          carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_d;
          cout_d  = fa_co;
          ovf_d   = c_msb ^ fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the single-bit full adder cell.
- Adds or subtracts two WIDTH-bit operands LSB-first, one bit per clock, through one full-adder cell and a registered carry.
- Start/busy/done handshake; result held stable until the next accepted operation.
- Used where area matters more than latency, and as a sequential exercise of the full adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out (for sub=1: 1 means no borrow, a>=b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, shift registers and counter cleared. A reset mid-operation aborts it; no done pulse is produced.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 loads the operands and moves to RUN.
  - RUN: one bit per edge.
  - DONE: lasts exactly one cycle, then goes to IDLE, or directly to RUN if start=1 in that cycle.
- Load at E0:
  - opa <= a; opb <= sub ? ~b : b; carry <= sub ? 1 : cin; cnt <= 0; busy=1 from E0.
- RUN edges E1..E_WIDTH:
  - The full-adder cell takes opa[0], opb[0] and carry.
  - Its sum bit shifts into the MSB of the result shift register; opa and opb shift right; carry <= cell cout; cnt increments.
  - At the bit where cnt=WIDTH-1, carry-in is saved as c_msb for overflow.
- Completion at E_WIDTH:
  - sum <= completed shift register; cout <= final carry; ovf <= c_msb ^ final carry.
  - State goes to DONE, so done=1 and busy=0 in the cycle after E_WIDTH.
  - Latency is WIDTH+1 edges from the start sample to the done cycle.
- sum, cout and ovf change only at completion and hold otherwise, including through IDLE and during a following operation.
- start while busy=1 is ignored, not queued. Input changes on a, b, sub and cin after E0 have no effect.
- Back-to-back: start=1 during the DONE cycle is accepted. done is a single-cycle pulse and never stretches.
- Arithmetic is modulo 2^WIDTH. Unsigned results read from sum plus cout; signed results use ovf.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - MODE_ADD/MODE_SUB constants.
- Sub-module fa_cell: pure combinational (a, b, cin -> s, cout), same function as the existing single-bit full adder.
- Exactly one fa_cell instance; the sequencing FSM, counter and shift registers live in serial_adder.

Test Plan (WIDTH=8):
- Add: a=8'h3C, b=8'h0F, cin=0, sub=0, start for 1 cycle.
  - Expect done exactly 9 edges after the start sample; busy high for 8 cycles before done.
  - Result sum=8'h4B, cout=0, ovf=0.
- Carry/overflow: a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- Subtract: a=8'h05, b=8'h07, sub=1, cin=1 (ignored).
  - Expect sum=8'hFE, cout=0 (borrow), ovf=0.
  - Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Handshake:
  - Pulse start again at cycle 3 of a run with different operands; it is ignored and the first result is unchanged.
  - Start asserted in the DONE cycle is accepted; its done arrives 9 edges later with the correct second result.
- Reset mid-operation: drop rst_n at RUN cycle 4 for 2 cycles.
  - All outputs read 0 immediately (asynchronous), with no done pulse.
  - A fresh add of 8'h10 and 8'h20 afterwards gives sum=8'h30.
- Exhaustive sweep: all 2^8 x 2^8 operand pairs x {add, sub} x cin{0,1}, checked against a behavioural model.
  - sum, cout and ovf match on every done pulse.
  - done pulse count equals the number of operations issued.
